// File: rtl/cascade_stage_evaluator.sv
// Per-window cascade stage evaluator: accumulates votes, compares against stage threshold.
// Define CASCADE_SAT_EN for saturating accumulation; otherwise the sum wraps.
module cascade_stage_evaluator #(
  parameter int NUM_STAGES = 22,
  parameter int STAGE_W    = 5,
  parameter int SUM_W      = 24,
  parameter int FRAC_W     = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               wc_valid,
  output logic               wc_ready,
  input  logic [SUM_W-1:0]   wc_value,
  input  logic               wc_last,
  output logic [STAGE_W-1:0] stage_num,
  input  logic [SUM_W-1:0]   thresh_value,
  output logic               busy,
  output logic               reject,
  output logic               done,
  output logic               face,
  output logic [STAGE_W:0]   exit_stage
);

  if (FRAC_W >= SUM_W) begin : g_bad_frac
    $error("FRAC_W must be smaller than SUM_W");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W:0]   EXIT_PASS  = (STAGE_W + 1)'(NUM_STAGES);

  state_e               state_q, state_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 reject_q, reject_d;
  logic                 face_q, face_d;
  logic [STAGE_W:0]     exit_q, exit_d;
  logic [SUM_W-1:0]     add_res;
  logic                 pass;

`ifdef CASCADE_SAT_EN
  logic [SUM_W:0] add_wide;

  // One guard bit exposes signed overflow; clamp toward the operand sign.
  always_comb begin
    add_wide = {sum_q[SUM_W-1], sum_q} + {wc_value[SUM_W-1], wc_value};
    add_res  = add_wide[SUM_W-1:0];
    if (add_wide[SUM_W] != add_wide[SUM_W-1]) begin
      add_res = add_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                : {1'b0, {(SUM_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    add_res = sum_q + wc_value;
  end
`endif

  assign pass = !($signed(sum_q) < $signed(thresh_value));

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    stage_d  = stage_q;
    reject_d = 1'b0;
    face_d   = face_q;
    exit_d   = exit_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d   = '0;
          stage_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (wc_valid) begin
          sum_d = add_res;
          if (wc_last) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!pass) begin
          face_d   = 1'b0;
          exit_d   = {1'b0, stage_q};
          reject_d = 1'b1;
          state_d  = S_DONE;
        end else if (stage_q == LAST_STAGE) begin
          face_d  = 1'b1;
          exit_d  = EXIT_PASS;
          state_d = S_DONE;
        end else begin
          stage_d = stage_q + 1'b1;
          sum_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      stage_q  <= '0;
      reject_q <= 1'b0;
      face_q   <= 1'b0;
      exit_q   <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      stage_q  <= stage_d;
      reject_q <= reject_d;
      face_q   <= face_d;
      exit_q   <= exit_d;
    end
  end

  assign wc_ready   = (state_q == S_ACCUM);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign reject     = reject_q;
  assign stage_num  = stage_q;
  assign face       = face_q;
  assign exit_stage = exit_q;

endmodule

// File: tb/tb_cascade_stage_evaluator.sv
// Bench for cascade_stage_evaluator: timeline built from the vote lists and a
// plain-arithmetic cascade model, checked every cycle.
module tb_cascade_stage_evaluator;
  localparam int NS = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        wc_valid;
  logic        wc_ready;
  logic [23:0] wc_value;
  logic        wc_last;
  logic [4:0]  stage_num;
  logic [23:0] thresh_value;
  logic        busy;
  logic        reject;
  logic        done;
  logic        face;
  logic [5:0]  exit_stage;

  int thr[32];
  int vq[NS][$];

  int total = 0;
  int bad = 0;

  bit exp_chk = 0;
  bit e_busy, e_ready, e_done, e_rej, e_cs, e_cr, e_face;
  int e_stage, e_exit;
  int last_face, last_exit;

  always #5 Clk = ~Clk;

  assign thresh_value = 24'(thr[stage_num]);

  cascade_stage_evaluator #(
    .NUM_STAGES(NS), .STAGE_W(5), .SUM_W(24), .FRAC_W(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .wc_valid(wc_valid), .wc_ready(wc_ready),
    .wc_value(wc_value), .wc_last(wc_last),
    .stage_num(stage_num), .thresh_value(thresh_value),
    .busy(busy), .reject(reject), .done(done),
    .face(face), .exit_stage(exit_stage)
  );

  task automatic check(string n, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_chk) begin
      check("busy", busy, e_busy);
      check("wc_ready", wc_ready, e_ready);
      check("done", done, e_done);
      check("reject", reject, e_rej);
      if (e_cs) check("stage_num", stage_num, e_stage);
      if (e_cr) begin
        check("face", face, e_face);
        check("exit_stage", exit_stage, e_exit);
      end
      if (done) begin
        last_face = int'(face);
        last_exit = int'(exit_stage);
      end
    end
  end

  function automatic longint acc(longint s, longint v);
    longint r = s + v;
`ifdef CASCADE_SAT_EN
    if (r > 8388607) r = 8388607;
    if (r < -8388608) r = -8388608;
`else
    r = r & 64'hFFFFFF;
    if (r >= 8388608) r = r - 16777216;
`endif
    return r;
  endfunction

  // Walk the cascade: first stage whose sum falls below threshold exits.
  task automatic model(output bit f, output int ex);
    longint s;
    f = 1;
    ex = NS;
    for (int st = 0; st < NS; st++) begin
      s = 0;
      foreach (vq[st][i]) s = acc(s, vq[st][i]);
      if (s < longint'(thr[st])) begin
        f = 0;
        ex = st;
        return;
      end
    end
  endtask

  task automatic step(bit rst, bit st, bit v, int val, bit lst,
                      bit eb, bit er, bit cs, int es,
                      bit ed, bit ej, bit cr, bit ef, int eex);
    @(posedge Clk);
    #1;
    Reset = rst; start = st; wc_valid = v;
    wc_value = 24'(val); wc_last = lst;
    e_busy = eb; e_ready = er; e_cs = cs; e_stage = es;
    e_done = ed; e_rej = ej; e_cr = cr; e_face = ef; e_exit = eex;
    exp_chk = 1;
  endtask

  function automatic bit coin(int n);
    return $urandom_range(n - 1) == 0;
  endfunction

  task automatic run_window(int pct, int abort_st);
    bit f;
    int ex, last_st, n;
    model(f, ex);
    last_st = f ? NS - 1 : ex;
    last_face = -1;
    last_exit = -1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int st = 0; st <= last_st; st++) begin
      n = vq[st].size();
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < 4 && $urandom_range(99) < pct; g++)
          step(0, coin(3), 0, int'($urandom), coin(2),
               1, 1, 1, st, 0, 0, 0, 0, 0);
        step(0, coin(4), 1, vq[st][i], i == n - 1,
             1, 1, 1, st, 0, 0, 0, 0, 0);
        if (st == abort_st) begin
          step(1, 0, 0, 0, 0, 1, 1, 1, st, 0, 0, 0, 0, 0);
          step(0, 0, coin(2), 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
          step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
          return;
        end
      end
      step(0, coin(3), coin(2), int'($urandom), coin(2),
           1, 0, 1, st, 0, 0, 0, 0, 0);
    end
    step(0, coin(3), coin(2), int'($urandom), 0,
         1, 0, 1, last_st, 1, !f, 1, f, ex);
    step(0, 0, coin(2), int'($urandom), 0,
         0, 0, 0, 0, 0, 0, 1, f, ex);
  endtask

  task automatic clr();
    for (int s = 0; s < NS; s++) vq[s].delete();
  endtask

  initial begin
    int n;
    Reset = 1; start = 0; wc_valid = 0; wc_value = '0; wc_last = 0;
    for (int i = 0; i < 32; i++) thr[i] = 0;
    repeat (2) @(posedge Clk);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);

    check("model_ovf", acc(acc(0, 6291456), 6291456),
`ifdef CASCADE_SAT_EN
          8388607);
`else
          -4194304);
`endif

    // stage-0 reject: 200 < 211
    clr();
    vq[0] = '{100, 100}; vq[1] = '{1}; vq[2] = '{1}; vq[3] = '{1};
    for (int s = 0; s < NS; s++) thr[s] = 211;
    run_window(0, -1);
    check("rej0_face", last_face, 0);
    check("rej0_exit", last_exit, 0);

    // stage 0 passes at 300, stage 1 fails at 1700 vs 1781
    clr();
    vq[0] = '{100, 200}; vq[1] = '{1000, 300, 400}; vq[2] = '{1}; vq[3] = '{1};
    thr[0] = 211; thr[1] = 1781;
    run_window(50, -1);
    check("multi_face", last_face, 0);
    check("multi_exit", last_exit, 1);

    // all pass with single-vote stages
    clr();
    vq[0] = '{100}; vq[1] = '{250}; vq[2] = '{-5}; vq[3] = '{211};
    thr[0] = 100; thr[1] = 211; thr[2] = -6; thr[3] = 211;
    run_window(30, -1);
    check("pass_face", last_face, 1);
    check("pass_exit", last_exit, NS);

    // overflow on stage 0
    clr();
    vq[0] = '{6291456, 6291456}; vq[1] = '{512}; vq[2] = '{512}; vq[3] = '{512};
    for (int s = 0; s < NS; s++) thr[s] = 256;
    run_window(0, -1);
`ifdef CASCADE_SAT_EN
    check("ovf_face", last_face, 1);
    check("ovf_exit", last_exit, NS);
`else
    check("ovf_face", last_face, 0);
    check("ovf_exit", last_exit, 0);
`endif

    // reset during stage 3, then a normal window
    clr();
    vq[0] = '{300}; vq[1] = '{150, 150}; vq[2] = '{300}; vq[3] = '{50, 60};
    for (int s = 0; s < NS; s++) thr[s] = 211;
    run_window(20, 3);
    check("rst_nodone", last_face, -1);
    clr();
    vq[0] = '{100, 150}; vq[1] = '{300}; vq[2] = '{100}; vq[3] = '{1};
    run_window(20, -1);
    check("post_rst_face", last_face, 0);
    check("post_rst_exit", last_exit, 2);

    for (int w = 0; w < 40; w++) begin
      clr();
      for (int s = 0; s < NS; s++) begin
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++)
          vq[s].push_back(int'($urandom_range(1000)) - 300);
        thr[s] = int'($urandom_range(1100)) - 200;
      end
      run_window(int'($urandom_range(60)), -1);
    end

    @(posedge Clk);
    #1;
    exp_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
